// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Optional build macro: BTB_CONF_EN adds a 2-bit confidence counter to every entry.
package btb_pkg;

   // Branch type encodings carried in each entry and returned per slot.
   localparam logic [1:0] BT_DIRECT   = 2'b00;
   localparam logic [1:0] BT_CALL     = 2'b01;
   localparam logic [1:0] BT_RETURN   = 2'b10;
   localparam logic [1:0] BT_INDIRECT = 2'b11;

   // Initialisation sweep states.
   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      READY = 1'b1
   } sweep_state_e;

   // Per-way payload. The tag sits in its own array so its width can follow TAG_W.
   typedef struct packed {
      logic        valid;
      logic [31:0] bta;
      logic [1:0]  btype;
`ifdef BTB_CONF_EN
      logic [1:0]  conf;
`endif
   } btb_entry_t;

   // XOR-fold the bits above the index into tag_w-bit chunks, LSB chunk first.
   // The caller passes the PC already shifted down, so the top chunk is zero padded.
   function automatic logic [31:0] fold_tag(input logic [31:0] upper, input int unsigned tag_w);
      logic [31:0] res;
      logic [4:0]  pos;
      res = 32'h0000_0000;
      for (int unsigned i = 0; i < 32; i++) begin
         pos      = 5'(i % tag_w);
         res[pos] = res[pos] ^ upper[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU helper: next state after touching a way, and the current victim.
// Node n of the tree (heap order, root = 1) lives in bit n-1; a 0 bit points the
// victim search to the left subtree, a 1 bit to the right one.
module btb_plru #(
   parameter int NUM_WAYS = 2,
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
   input  logic [PLRU_W-1:0] plru_state,
   input  logic              touch_en,
   input  logic [WAY_W-1:0]  touch_way,
   output logic [PLRU_W-1:0] plru_next,
   output logic [WAY_W-1:0]  victim
);

   generate
      if (NUM_WAYS == 1) begin : g_direct
         // A single way has no replacement state; the victim is always way 0.
         assign plru_next = plru_state;
         assign victim    = 1'b0;
      end else begin : g_tree
         logic [PLRU_W-1:0] next_s;
         logic [WAY_W-1:0]  victim_s;

         // Touch: along the path to touch_way, point every node away from it.
         always_comb begin
            int node;
            int dir;
            int tw;
            next_s = plru_state;
            node   = 1;
            dir    = 0;
            tw     = int'(touch_way);
            if (touch_en) begin
               for (int lvl = 0; lvl < WAY_W; lvl++) begin
                  dir  = (tw >> (WAY_W - 1 - lvl)) & 1;
                  node = (1 << lvl) + (tw >> (WAY_W - lvl));
                  if (dir == 0) begin
                     next_s = next_s | (PLRU_W'(1) << (node - 1));
                  end else begin
                     next_s = next_s & ~(PLRU_W'(1) << (node - 1));
                  end
               end
            end else begin
               next_s = plru_state;
            end
         end

         // Victim: follow the node bits from the root down to a leaf.
         always_comb begin
            int node;
            node = 1;
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
               node = 2 * node + ((int'(plru_state) >> (node - 1)) & 1);
            end
            victim_s = WAY_W'(node - NUM_WAYS);
         end

         assign plru_next = next_s;
         assign victim    = victim_s;
      end
   endgenerate

endmodule

// File: rtl/btb_assoc_multi.sv
// Set-associative, FETCH_WIDTH-banked branch target buffer with per-slot lookup,
// one resolved-branch update per cycle, tree PLRU replacement and an init sweep.
// Optional build macro: BTB_CONF_EN (2-bit confidence guarding target overwrite).
module btb_assoc_multi
   import btb_pkg::*;
#(
   parameter int FETCH_WIDTH = 4,
   parameter int NUM_SETS    = 32,
   parameter int NUM_WAYS    = 2,
   parameter int TAG_W       = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   output logic                     init_done,
   input  logic [31:0]              pc,
   input  logic [FETCH_WIDTH-1:0]   inst_bj,
   output logic [FETCH_WIDTH-1:0]   hit,
   output logic [32*FETCH_WIDTH-1:0] bta,
   output logic [2*FETCH_WIDTH-1:0] btype,
   input  logic                     update_en,
   input  logic [31:0]              update_pc,
   input  logic [1:0]               update_type,
   input  logic [31:0]              update_bta
);

   localparam int OFF    = 2 + $clog2(FETCH_WIDTH);
   localparam int IW     = $clog2(NUM_SETS);
   localparam int BW     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

   // Storage
   btb_entry_t        entry_r [FETCH_WIDTH][NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]  tag_r   [FETCH_WIDTH][NUM_SETS][NUM_WAYS];
   logic [PLRU_W-1:0] plru_r  [FETCH_WIDTH][NUM_SETS];

   // Sweep FSM
   sweep_state_e state_r, state_nxt_s;
   logic [IW-1:0] cnt_r, cnt_nxt_s;
   logic          init_done_r, done_nxt_s;
   logic          sweep_clr_s;

   // Address decode
   logic [IW-1:0]    fidx_s, uidx_s;
   logic [BW-1:0]    ubank_s;
   logic [31:0]      ftag_full_s, utag_full_s, pc_base_s;
   logic [TAG_W-1:0] ftag_s, utag_s;

   // Lookup path
   logic [FETCH_WIDTH-1:0]    hit_s, ltouch_s;
   logic [32*FETCH_WIDTH-1:0] bta_s;
   logic [2*FETCH_WIDTH-1:0]  btype_s;
   logic [WAY_W-1:0]          lway_s    [FETCH_WIDTH];
   logic [PLRU_W-1:0]         lplru_nxt_s [FETCH_WIDTH];
   logic [WAY_W-1:0]          lvictim_s [FETCH_WIDTH];
   logic                      lkp_wr_ok_s;

   // Update path
   logic              upd_ok_s, uhit_s, ufree_s;
   logic [WAY_W-1:0]  uhway_s, ufree_way_s, uvictim_s, uway_s;
   logic [PLRU_W-1:0] uplru_base_s, uplru_nxt_s;
   btb_entry_t        uold_s, unew_s;

   assign fidx_s      = IW'(pc >> OFF);
   assign uidx_s      = IW'(update_pc >> OFF);
   assign ubank_s     = (FETCH_WIDTH > 1) ? BW'(update_pc >> 2) : BW'(0);
   assign ftag_full_s = fold_tag(pc >> (OFF + IW), TAG_W);
   assign utag_full_s = fold_tag(update_pc >> (OFF + IW), TAG_W);
   assign ftag_s      = ftag_full_s[TAG_W-1:0];
   assign utag_s      = utag_full_s[TAG_W-1:0];
   assign pc_base_s   = (pc >> OFF) << OFF;

   // Sweep FSM next state: walk the sets once, then sit in READY until reset/flush.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_nxt_s  = init_done_r;
      sweep_clr_s = 1'b0;
      case (state_r)
         SWEEP: begin
            sweep_clr_s = 1'b1;
            cnt_nxt_s   = cnt_r + IW'(1);
            if (cnt_r == IW'(NUM_SETS - 1)) begin
               state_nxt_s = READY;
               done_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = SWEEP;
               done_nxt_s  = 1'b0;
            end
         end
         READY: begin
            state_nxt_s = READY;
            done_nxt_s  = 1'b1;
         end
         default: begin
            state_nxt_s = SWEEP;
            cnt_nxt_s   = '0;
            done_nxt_s  = 1'b0;
         end
      endcase
      if (reset || flush) begin
         state_nxt_s = SWEEP;
         cnt_nxt_s   = '0;
         done_nxt_s  = 1'b0;
         sweep_clr_s = 1'b0;
      end else begin
         sweep_clr_s = sweep_clr_s & ~reset;
      end
   end

   // Sweep FSM registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= SWEEP;
         cnt_r       <= '0;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         init_done_r <= done_nxt_s;
      end
   end

   assign lkp_wr_ok_s = (state_r == READY) && !reset && !flush;
   assign upd_ok_s    = update_en && lkp_wr_ok_s;

   // Per-slot lookup: lowest matching valid way wins; misses fall through to the next PC.
   always_comb begin
      logic lmatch;
      hit_s   = '0;
      bta_s   = '0;
      btype_s = '0;
      lmatch  = 1'b0;
      for (int b = 0; b < FETCH_WIDTH; b++) begin
         lway_s[b] = '0;
         for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            lmatch    = (state_r == READY) && entry_r[b][fidx_s][w].valid
                        && (tag_r[b][fidx_s][w] == ftag_s);
            lway_s[b] = lmatch ? WAY_W'(w) : lway_s[b];
            hit_s[b]  = hit_s[b] | lmatch;
         end
         if (hit_s[b]) begin
            bta_s[32*b +: 32] = entry_r[b][fidx_s][lway_s[b]].bta;
            btype_s[2*b +: 2] = entry_r[b][fidx_s][lway_s[b]].btype;
         end else begin
            bta_s[32*b +: 32] = pc_base_s + 32'(4 * (b + 1));
            btype_s[2*b +: 2] = BT_DIRECT;
         end
      end
   end

   assign ltouch_s = hit_s & inst_bj;

   generate
      for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lkp_plru
         btb_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
            .plru_state (plru_r[g][fidx_s]),
            .touch_en   (ltouch_s[g]),
            .touch_way  (lway_s[g]),
            .plru_next  (lplru_nxt_s[g]),
            .victim     (lvictim_s[g])
         );
      end
   endgenerate

   // Update way selection: tag hit first, else lowest invalid way, else PLRU victim.
   // The PLRU base already includes a same-cycle lookup touch on that bank/set.
   always_comb begin
      logic umatch;
      logic ufree;
      uhit_s      = 1'b0;
      ufree_s     = 1'b0;
      uhway_s     = '0;
      ufree_way_s = '0;
      umatch      = 1'b0;
      ufree       = 1'b0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         umatch      = entry_r[ubank_s][uidx_s][w].valid && (tag_r[ubank_s][uidx_s][w] == utag_s);
         ufree       = !entry_r[ubank_s][uidx_s][w].valid;
         uhway_s     = umatch ? WAY_W'(w) : uhway_s;
         ufree_way_s = ufree ? WAY_W'(w) : ufree_way_s;
         uhit_s      = uhit_s | umatch;
         ufree_s     = ufree_s | ufree;
      end
      if (fidx_s == uidx_s) begin
         uplru_base_s = lplru_nxt_s[ubank_s];
      end else begin
         uplru_base_s = plru_r[ubank_s][uidx_s];
      end
      if (uhit_s) begin
         uway_s = uhway_s;
      end else if (ufree_s) begin
         uway_s = ufree_way_s;
      end else begin
         uway_s = uvictim_s;
      end
   end

   btb_plru #(.NUM_WAYS(NUM_WAYS)) u_upd_plru (
      .plru_state (uplru_base_s),
      .touch_en   (upd_ok_s),
      .touch_way  (uway_s),
      .plru_next  (uplru_nxt_s),
      .victim     (uvictim_s)
   );

   // New contents of the selected way.
   always_comb begin
      uold_s       = entry_r[ubank_s][uidx_s][uway_s];
      unew_s       = uold_s;
      unew_s.valid = 1'b1;
      unew_s.btype = update_type;
`ifdef BTB_CONF_EN
      if (uhit_s) begin
         if (uold_s.bta == update_bta) begin
            unew_s.bta  = uold_s.bta;
            unew_s.conf = (uold_s.conf == 2'b11) ? 2'b11 : uold_s.conf + 2'b01;
         end else if (uold_s.conf != 2'b00) begin
            unew_s.bta  = uold_s.bta;
            unew_s.conf = uold_s.conf - 2'b01;
         end else begin
            unew_s.bta  = update_bta;
            unew_s.conf = 2'b01;
         end
      end else begin
         unew_s.bta  = update_bta;
         unew_s.conf = 2'b01;
      end
`else
      unew_s.bta = update_bta;
`endif
   end

   // Array writes: sweep clear, lookup PLRU touches, then the update (its touch lands last).
   always_ff @(posedge clk) begin
      if (sweep_clr_s) begin
         for (int b = 0; b < FETCH_WIDTH; b++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               entry_r[b][cnt_r][w].valid <= 1'b0;
            end
            plru_r[b][cnt_r] <= '0;
         end
      end else begin
         for (int b = 0; b < FETCH_WIDTH; b++) begin
            if (lkp_wr_ok_s && ltouch_s[b]) begin
               plru_r[b][fidx_s] <= lplru_nxt_s[b];
            end
         end
         if (upd_ok_s) begin
            entry_r[ubank_s][uidx_s][uway_s] <= unew_s;
            tag_r[ubank_s][uidx_s][uway_s]   <= utag_s;
            plru_r[ubank_s][uidx_s]          <= uplru_nxt_s;
         end
      end
   end

   assign init_done = init_done_r;
   assign hit       = hit_s;
   assign bta       = bta_s;
   assign btype     = btype_s;

endmodule

// File: tb/tb_btb_assoc_multi.sv
// Self-checking bench for btb_assoc_multi (default parameters). Directed scenarios
// plus a randomized run against a set/way reference model. Honors BTB_CONF_EN.
module tb_btb_assoc_multi;

   logic         clk = 1'b0;
   logic         reset, flush, init_done;
   logic [31:0]  pc;
   logic [3:0]   inst_bj, hit;
   logic [127:0] bta;
   logic [7:0]   btype;
   logic         update_en;
   logic [31:0]  update_pc, update_bta;
   logic [1:0]   update_type;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bank x set x way contents, MRU way per set (2-way tree == LRU).
   bit          m_valid [4][32][2];
   logic [9:0]  m_tag   [4][32][2];
   logic [31:0] m_bta   [4][32][2];
   logic [1:0]  m_type  [4][32][2];
   logic [1:0]  m_conf  [4][32][2];
   int          m_mru   [4][32];
   bit          m_ready = 1'b0;
   int          m_left  = 0;

   always #5 clk = ~clk;

   btb_assoc_multi dut (
      .clk(clk), .reset(reset), .flush(flush), .init_done(init_done),
      .pc(pc), .inst_bj(inst_bj), .hit(hit), .bta(bta), .btype(btype),
      .update_en(update_en), .update_pc(update_pc), .update_type(update_type),
      .update_bta(update_bta)
   );

   function automatic logic [9:0] ref_tag(input logic [31:0] a);
      return a[18:9] ^ a[28:19] ^ {7'b0, a[31:29]};
   endfunction

   task automatic model_lookup(input logic [31:0] a, output logic [3:0] eh,
                               output logic [127:0] eb, output logic [7:0] et,
                               output logic [7:0] ew);
      int ix;
      ix = int'(a[8:4]);
      eh = 4'b0; eb = 128'b0; et = 8'b0; ew = 8'b0;
      for (int s = 0; s < 4; s++) begin
         eb[32*s +: 32] = {a[31:4], 4'b0} + 32'(4 * (s + 1));
         if (m_ready) begin
            for (int w = 1; w >= 0; w--) begin
               if (m_valid[s][ix][w] && m_tag[s][ix][w] == ref_tag(a)) begin
                  eh[s] = 1'b1;
                  eb[32*s +: 32] = m_bta[s][ix][w];
                  et[2*s +: 2] = m_type[s][ix][w];
                  ew[2*s +: 2] = 2'(w);
               end
            end
         end
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      logic [3:0] eh; logic [127:0] eb; logic [7:0] et; logic [7:0] ew;
      int b, ix, w;
      if (reset || flush) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 32; j++) begin
               m_valid[i][j][0] = 1'b0; m_valid[i][j][1] = 1'b0; m_mru[i][j] = 1;
            end
         m_ready = 1'b0; m_left = 32;
      end else if (!m_ready) begin
         m_left--;
         if (m_left == 0) m_ready = 1'b1;
      end else begin
         model_lookup(pc, eh, eb, et, ew);
         for (int s = 0; s < 4; s++)
            if (eh[s] && inst_bj[s]) m_mru[s][int'(pc[8:4])] = int'(ew[2*s +: 2]);
         if (update_en) begin
            b = int'(update_pc[3:2]); ix = int'(update_pc[8:4]); w = -1;
            for (int k = 1; k >= 0; k--)
               if (m_valid[b][ix][k] && m_tag[b][ix][k] == ref_tag(update_pc)) w = k;
            if (w >= 0) begin
`ifdef BTB_CONF_EN
               if (m_bta[b][ix][w] == update_bta) begin
                  if (m_conf[b][ix][w] != 2'd3) m_conf[b][ix][w]++;
               end else if (m_conf[b][ix][w] != 2'd0) begin
                  m_conf[b][ix][w]--;
               end else begin
                  m_bta[b][ix][w] = update_bta; m_conf[b][ix][w] = 2'd1;
               end
`else
               m_bta[b][ix][w] = update_bta;
`endif
               m_type[b][ix][w] = update_type;
            end else begin
               for (int k = 1; k >= 0; k--) if (!m_valid[b][ix][k]) w = k;
               if (w < 0) w = 1 - m_mru[b][ix];
               m_valid[b][ix][w] = 1'b1; m_tag[b][ix][w] = ref_tag(update_pc);
               m_bta[b][ix][w] = update_bta; m_type[b][ix][w] = update_type;
               m_conf[b][ix][w] = 2'd1;
            end
            m_mru[b][ix] = w;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_update(input logic [31:0] a, input logic [31:0] t, input logic [1:0] ty);
      update_en = 1'b1; update_pc = a; update_bta = t; update_type = ty;
      tick();
      update_en = 1'b0;
   endtask

   localparam logic [31:0] PC_A = 32'h0001_0000, PC_B = 32'h0002_0000, PC_C = 32'h0004_0000;
   localparam logic [31:0] PC_D = 32'h0008_0010, PC_E = 32'h0010_0020;

   task automatic test_reset();
      reset = 1'b1; pc = 32'h1000;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         n_checks++;
         if (init_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_init_low cycle %0d: got %b want 0", i, init_done);
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if (init_done !== 1'b1) begin n_fail++; $display("FAIL reset_init_high: got %b want 1", init_done); end
      n_checks++;
      if (hit !== 4'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0000", hit); end
      n_checks++;
      if (bta !== {32'h1010, 32'h100C, 32'h1008, 32'h1004}) begin
         n_fail++; $display("FAIL reset_fallthrough: got %h", bta);
      end
      tick();
   endtask

   task automatic test_basic_update();
      do_update(32'h2008, 32'h3000, 2'b01);
      pc = 32'h2000;
      @(negedge clk);
      n_checks++;
      if (hit !== 4'b0100) begin n_fail++; $display("FAIL basic_hit: got %b want 0100", hit); end
      n_checks++;
      if (bta[95:64] !== 32'h3000) begin n_fail++; $display("FAIL basic_bta: got %h want 3000", bta[95:64]); end
      n_checks++;
      if (btype[5:4] !== 2'b01) begin n_fail++; $display("FAIL basic_type: got %b want 01", btype[5:4]); end
      n_checks++;
      if (bta[31:0] !== 32'h2004) begin n_fail++; $display("FAIL basic_miss_slot0: got %h want 2004", bta[31:0]); end
      tick();
   endtask

   task automatic test_plru_evict();
      do_update(PC_A, 32'hA0, 2'b00);
      do_update(PC_B, 32'hB0, 2'b00);
      pc = PC_A; inst_bj = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (hit[0] !== 1'b1 || bta[31:0] !== 32'hA0) begin
         n_fail++; $display("FAIL plru_touch_a: got hit %b bta %h want 1 a0", hit[0], bta[31:0]);
      end
      tick();
      inst_bj = 4'b0;
      do_update(PC_C, 32'hC0, 2'b00);
      pc = PC_B;
      @(negedge clk);
      n_checks++;
      if (hit[0] !== 1'b0) begin n_fail++; $display("FAIL plru_b_evicted: got %b want 0", hit[0]); end
      tick();
      pc = PC_A;
      @(negedge clk);
      n_checks++;
      if (hit[0] !== 1'b1 || bta[31:0] !== 32'hA0) begin
         n_fail++; $display("FAIL plru_a_kept: got hit %b bta %h", hit[0], bta[31:0]);
      end
      tick();
      pc = PC_C;
      @(negedge clk);
      n_checks++;
      if (hit[0] !== 1'b1 || bta[31:0] !== 32'hC0) begin
         n_fail++; $display("FAIL plru_c_alloc: got hit %b bta %h", hit[0], bta[31:0]);
      end
      tick();
   endtask

   task automatic test_overwrite();
      logic [31:0] exp_a;
`ifdef BTB_CONF_EN
      exp_a = 32'hA0;
`else
      exp_a = 32'hAA;
`endif
      do_update(PC_A, 32'hAA, 2'b11);
      pc = PC_A;
      @(negedge clk);
      n_checks++;
      if (hit[0] !== 1'b1 || bta[31:0] !== exp_a || btype[1:0] !== 2'b11) begin
         n_fail++; $display("FAIL overwrite_a: got hit %b bta %h type %b want 1 %h 11", hit[0], bta[31:0], btype[1:0], exp_a);
      end
      tick();
      pc = PC_C;
      @(negedge clk);
      n_checks++;
      if (hit[0] !== 1'b1 || bta[31:0] !== 32'hC0) begin
         n_fail++; $display("FAIL overwrite_c_intact: got hit %b bta %h", hit[0], bta[31:0]);
      end
      tick();
   endtask

   task automatic test_flush();
      int cyc;
      logic [31:0] pcs [4];
      pcs = '{PC_A, PC_C, PC_D, PC_E};
      flush = 1'b1;
      do_update(PC_D, 32'hD0, 2'b00);
      flush = 1'b0; pc = PC_A;
      @(negedge clk);
      n_checks++;
      if (init_done !== 1'b0 || hit !== 4'b0) begin
         n_fail++; $display("FAIL flush_sweep: got init %b hit %b want 0 0000", init_done, hit);
      end
      do_update(PC_E, 32'hE0, 2'b00);
      cyc = 1;
      while (!init_done && cyc < 40) begin tick(); cyc++; end
      n_checks++;
      if (cyc != 32) begin n_fail++; $display("FAIL flush_sweep_len: got %0d cycles want 32", cyc); end
      for (int i = 0; i < 4; i++) begin
         pc = pcs[i];
         @(negedge clk);
         n_checks++;
         if (hit !== 4'b0) begin n_fail++; $display("FAIL flush_miss %0d: got %b want 0000", i, hit); end
         tick();
      end
   endtask

`ifdef BTB_CONF_EN
   task automatic test_conf();
      logic [31:0] pcx;
      pcx = 32'h0020_0030;
      for (int i = 0; i < 3; i++) do_update(pcx, 32'h4000, 2'b00);
      for (int i = 0; i < 3; i++) do_update(pcx, 32'h5000, 2'b00);
      pc = pcx;
      @(negedge clk);
      n_checks++;
      if (bta[31:0] !== 32'h4000) begin n_fail++; $display("FAIL conf_keep: got %h want 4000", bta[31:0]); end
      tick();
      do_update(pcx, 32'h5000, 2'b00);
      @(negedge clk);
      n_checks++;
      if (bta[31:0] !== 32'h5000) begin n_fail++; $display("FAIL conf_replace: got %h want 5000", bta[31:0]); end
      tick();
   endtask
`endif

   function automatic logic [31:0] rnd_pc();
      return (32'($urandom_range(1, 5)) << 19) | (32'($urandom_range(0, 3)) << 4)
             | (32'($urandom_range(0, 3)) << 2);
   endfunction

   task automatic test_random();
      logic [3:0] eh; logic [127:0] eb; logic [7:0] et; logic [7:0] ew;
      for (int i = 0; i < 800; i++) begin
         pc = rnd_pc(); inst_bj = 4'($urandom);
         update_en = ($urandom_range(0, 1) == 1); update_pc = rnd_pc();
         update_bta = 32'h100 * $urandom_range(1, 3); update_type = 2'($urandom);
         flush = ($urandom_range(0, 149) == 0); reset = ($urandom_range(0, 399) == 0);
         @(negedge clk);
         model_lookup(pc, eh, eb, et, ew);
         n_checks++;
         if (hit !== eh || bta !== eb || btype !== et || init_done !== m_ready) begin
            n_fail++;
            $display("FAIL rand cycle %0d pc %h: hit %b/%b type %h/%h init %b/%b", i, pc, hit, eh, btype, et, init_done, m_ready);
         end
         tick();
      end
      reset = 1'b0; flush = 1'b0; update_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; pc = 32'h0; inst_bj = 4'b0;
      update_en = 1'b0; update_pc = 32'h0; update_bta = 32'h0; update_type = 2'b00;
      test_reset();
      test_basic_update();
      test_plru_evict();
      test_overwrite();
      test_flush();
`ifdef BTB_CONF_EN
      test_conf();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
